exe_stage: RTL and testbench

- Execute stage of the 5-stage LoongArch pipeline. Sits directly downstream of the decode stage.
- Latches the decode-to-execute bus and computes the ALU, multiply and divide results.
- Issues the data-SRAM request for loads and stores, and hands the result to the memory stage over a valid/allowin handshake.
- Drives the execute-stage forwarding bus used by decode for bypass and load-use stall detection.

---
 rtl/exe_stage.sv | 267 ++++++++++++++++++++++++++
 tb/tb_exe_stage.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// exe_stage -- execute stage of the 5-stage LoongArch pipeline.
//
// Latches the decode-to-execute bus, computes ALU / multiply / divide
// results, issues the data-SRAM request for loads and stores, and hands the
// instruction to the memory stage over a valid/allowin handshake. Also drives
// the forwarding bus that decode uses for bypass and load-use detection.
//
// Optional build macro:
//   ES_DIV_ZERO_FAST_EN  when defined, a divide by zero skips the iterative
//                        loop and completes with 2-cycle ES residency.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   ds_to_es_valid    decode output valid
//   ds_to_es_bus      decode payload (DS_BUS_WD bits)
//   es_allowin        execute stage can accept a new instruction
//   ms_allowin        memory stage can accept
//   es_to_ms_valid    output valid to memory stage
//   es_to_ms_bus      output payload (MS_BUS_WD bits)
//   es_forward        forwarding bus (FWD_WD bits)
//   data_sram_en      data SRAM request
//   data_sram_we      byte write enables
//   data_sram_addr    byte address
//   data_sram_wdata   store data
//
// Divider FSM:
//   state     | meaning
//   DIV_IDLE  | no divide in flight; latch operands when a div op is in ES
//   DIV_BUSY  | one restoring quotient bit per cycle, 32 iterations
//   DIV_DONE  | result valid and held until the memory stage accepts it

module exe_stage #(
  parameter int DS_BUS_WD = 167,
  parameter int MS_BUS_WD = 76,
  parameter int FWD_WD    = 72
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ds_to_es_valid,
  input  logic [DS_BUS_WD-1:0] ds_to_es_bus,
  output logic                 es_allowin,
  input  logic                 ms_allowin,
  output logic                 es_to_ms_valid,
  output logic [MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [FWD_WD-1:0]    es_forward,
  output logic                 data_sram_en,
  output logic [3:0]           data_sram_we,
  output logic [31:0]          data_sram_addr,
  output logic [31:0]          data_sram_wdata
);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  logic                 es_valid;
  logic                 es_ready_go;
  logic [DS_BUS_WD-1:0] es_bus;

  // ---------------------------------------------------------------- bus fields
  logic [31:0] pc, imm, rk_value, rj_value;
  logic        ld_b, ld_h, ld_w, st_b, st_h, st_w, ld_bu, ld_hu;
  logic        src1_is_pc, src2_is_imm, src2_is_4;
  logic [18:0] alu_op;
  logic        mem_en, mem_we, gr_we, res_from_mem;
  logic [4:0]  dest;

  assign pc           = es_bus[166:135];
  assign ld_b         = es_bus[134];
  assign ld_h         = es_bus[133];
  assign ld_w         = es_bus[132];
  assign st_b         = es_bus[131];
  assign st_h         = es_bus[130];
  assign st_w         = es_bus[129];
  assign ld_bu        = es_bus[128];
  assign ld_hu        = es_bus[127];
  assign imm          = es_bus[126:95];
  assign rk_value     = es_bus[94:63];
  assign rj_value     = es_bus[62:31];
  assign src1_is_pc   = es_bus[30];
  assign src2_is_imm  = es_bus[29];
  assign src2_is_4    = es_bus[28];
  assign alu_op       = es_bus[27:9];
  assign mem_en       = es_bus[8];
  assign mem_we       = es_bus[7];
  assign dest         = es_bus[6:2];
  assign gr_we        = es_bus[1];
  assign res_from_mem = es_bus[0];

  // ----------------------------------------------------------------- handshake
  assign es_allowin     = ~es_valid | (es_ready_go & ms_allowin);
  assign es_to_ms_valid = es_valid & es_ready_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid <= 1'b0;
    end else if (es_allowin) begin
      es_valid <= ds_to_es_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (ds_to_es_valid & es_allowin) begin
      es_bus <= ds_to_es_bus;
    end
  end

  // ------------------------------------------------------------------ operands
  logic [31:0] src1, src2;

  assign src1 = src1_is_pc  ? pc  : rj_value;
  assign src2 = src2_is_imm ? imm : (src2_is_4 ? 32'd4 : rk_value);

  // ----------------------------------------------------------------------- ALU
  logic [31:0] add_res, sub_res, alu_result;

  assign add_res = src1 + src2;
  assign sub_res = src1 - src2;

  always_comb begin
    alu_result = 32'd0;
    case (1'b1)
      alu_op[0]:  alu_result = add_res;
      alu_op[1]:  alu_result = sub_res;
      alu_op[2]:  alu_result = {31'd0, $signed(src1) < $signed(src2)};
      alu_op[3]:  alu_result = {31'd0, src1 < src2};
      alu_op[4]:  alu_result = src1 & src2;
      alu_op[5]:  alu_result = ~(src1 | src2);
      alu_op[6]:  alu_result = src1 | src2;
      alu_op[7]:  alu_result = src1 ^ src2;
      alu_op[8]:  alu_result = src1 << src2[4:0];
      alu_op[9]:  alu_result = src1 >> src2[4:0];
      alu_op[10]: alu_result = $unsigned($signed(src1) >>> src2[4:0]);
      alu_op[11]: alu_result = src2;
      default:    alu_result = 32'd0;
    endcase
  end

  // ------------------------------------------------------------------ multiply
  // One 64x64 multiplier: operands are sign- or zero-extended so the low 64
  // bits give the signed or unsigned product; mul.w only needs the low word.
  logic        mul_op, mul_signed;
  logic [63:0] mul_a, mul_b, mul_prod;
  logic [31:0] mul_result;

  assign mul_op     = |alu_op[14:12];
  assign mul_signed = alu_op[13];
  assign mul_a      = {{32{mul_signed & src1[31]}}, src1};
  assign mul_b      = {{32{mul_signed & src2[31]}}, src2};
  assign mul_prod   = mul_a * mul_b;
  assign mul_result = alu_op[12] ? mul_prod[31:0] : mul_prod[63:32];

  // ------------------------------------------------------------------- divide
  // Signs and the zero-divisor flag are taken straight from the bus register,
  // which cannot change while the divide occupies the stage.
  div_state_t  div_state;
  logic [4:0]  div_cnt;
  logic [31:0] div_rem, div_quo, div_dsor;
  logic        div_op, div_signed, div_is_mod, div_zero;
  logic        neg_q, neg_r;
  logic [31:0] dvd_abs, dsor_abs;
  logic [32:0] step_sh, step_diff;
  logic [31:0] q_fix, r_fix, div_result;

  assign div_op     = |alu_op[18:15];
  assign div_signed = alu_op[15] | alu_op[17];
  assign div_is_mod = alu_op[17] | alu_op[18];
  assign div_zero   = (src2 == 32'd0);
  assign neg_q      = div_signed & (src1[31] ^ src2[31]);
  assign neg_r      = div_signed & src1[31];
  assign dvd_abs    = (div_signed & src1[31]) ? (32'd0 - src1) : src1;
  assign dsor_abs   = (div_signed & src2[31]) ? (32'd0 - src2) : src2;

  // Restoring step: bring in the next dividend bit, subtract if it fits.
  assign step_sh   = {div_rem, div_quo[31]};
  assign step_diff = step_sh - {1'b0, div_dsor};

  always_ff @(posedge clk) begin
    if (reset) begin
      div_state <= DIV_IDLE;
      div_cnt   <= 5'd0;
      div_rem   <= 32'd0;
      div_quo   <= 32'd0;
      div_dsor  <= 32'd0;
    end else begin
      case (div_state)
        DIV_IDLE: begin
          if (es_valid & div_op) begin
            div_rem  <= 32'd0;
            div_quo  <= dvd_abs;
            div_dsor <= dsor_abs;
            div_cnt  <= 5'd0;
`ifdef ES_DIV_ZERO_FAST_EN
            div_state <= div_zero ? DIV_DONE : DIV_BUSY;
`else
            div_state <= DIV_BUSY;
`endif
          end
        end
        DIV_BUSY: begin
          div_rem   <= step_diff[32] ? step_sh[31:0] : step_diff[31:0];
          div_quo   <= {div_quo[30:0], ~step_diff[32]};
          div_cnt   <= div_cnt + 5'd1;
          if (div_cnt == 5'd31) begin
            div_state <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (ms_allowin) begin
            div_state <= DIV_IDLE;
          end
        end
        default: div_state <= DIV_IDLE;
      endcase
    end
  end

  // Zero divisor overrides the loop output so signed ops keep the raw values.
  assign q_fix      = div_zero ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - div_quo) : div_quo);
  assign r_fix      = div_zero ? src1 : (neg_r ? (32'd0 - div_rem) : div_rem);
  assign div_result = div_is_mod ? r_fix : q_fix;

  assign es_ready_go = ~div_op | (div_state == DIV_DONE);

  // ---------------------------------------------------------------- result mux
  logic [31:0] es_result;

  assign es_result = div_op ? div_result : (mul_op ? mul_result : alu_result);

  // -------------------------------------------------------------------- memory
  logic [3:0]  st_mask;
  logic [31:0] st_data;

  assign data_sram_addr = add_res;

  always_comb begin
    st_mask = 4'b0000;
    st_data = rk_value;
    if (st_b) begin
      st_mask = 4'b0001 << data_sram_addr[1:0];
      st_data = {4{rk_value[7:0]}};
    end else if (st_h) begin
      st_mask = data_sram_addr[1] ? 4'b1100 : 4'b0011;
      st_data = {2{rk_value[15:0]}};
    end else if (st_w) begin
      st_mask = 4'b1111;
    end
  end

  // Gating on ms_allowin issues the request only in the cycle the
  // instruction actually moves on, so a stall never repeats it.
  assign data_sram_en    = es_valid & mem_en & es_ready_go & ms_allowin;
  assign data_sram_we    = mem_we ? st_mask : 4'b0000;
  assign data_sram_wdata = st_data;

  // ------------------------------------------------------------------- outputs
  logic is_load;

  assign is_load = ld_b | ld_h | ld_w | ld_bu | ld_hu;

  assign es_to_ms_bus = {ld_b, ld_h, ld_w, ld_bu, ld_hu, pc, es_result,
                         dest, gr_we, res_from_mem};
  assign es_forward   = {is_load, pc, es_result, dest, gr_we, es_valid};

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         ds_to_es_valid;
  logic [166:0] ds_to_es_bus;
  logic         es_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [75:0]  es_to_ms_bus;
  logic [71:0]  es_forward;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  int checks   = 0;
  int failures = 0;

  localparam int OP_ADD = 0, OP_DIVW = 15, OP_DIVWU = 16, OP_MODW = 17, OP_MODWU = 18;
  localparam logic [7:0] LS_NONE = 8'b0000_0000, LS_LDW = 8'b0010_0000,
                         LS_STB = 8'b0001_0000, LS_STH = 8'b0000_1000,
                         LS_STW = 8'b0000_0100;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ds_to_es_valid  (ds_to_es_valid),
    .ds_to_es_bus    (ds_to_es_bus),
    .es_allowin      (es_allowin),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .es_forward      (es_forward),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  function automatic logic [166:0] mk(input logic [31:0] pc, input logic [7:0] lsf,
                                      input logic [31:0] imm, input logic [31:0] rk,
                                      input logic [31:0] rj, input logic s2imm,
                                      input int op, input logic men, input logic mwe,
                                      input logic [4:0] dest, input logic gwe,
                                      input logic rfm);
    logic [18:0] oh;
    oh = 19'd1 << op;
    return {pc, lsf, imm, rk, rj, 1'b0, s2imm, 1'b0, oh, men, mwe, dest, gwe, rfm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ALU / multiply vectors: op, rj (src1), rk (src2), expected result.
  int          alu_op_t[15] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14};
  logic [31:0] alu_a_t[15]  = '{32'd5, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0,
                                32'd1, 32'h8000_0000, 32'h8000_0000, 32'hDEAD_BEEF,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] alu_b_t[15]  = '{32'd7, 32'd7, 32'd1, 32'd1,
                                32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00,
                                32'h0000_0024, 32'd31, 32'd4, 32'h1234_5000,
                                32'd3, 32'd3, 32'd3};
  logic [31:0] alu_e_t[15]  = '{32'd12, 32'hFFFF_FFFE, 32'd1, 32'd0,
                                32'hF000_F000, 32'h000F_000F, 32'hFFF0_FFF0, 32'h0FF0_0FF0,
                                32'h0000_0010, 32'd1, 32'hF800_0000, 32'h1234_5000,
                                32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2};

  task automatic test_reset();
    reset = 1'b1;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus = '0;
    ms_allowin = 1'b1;
    step();
    step();
    checks++; if (es_to_ms_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", es_to_ms_valid); end
    checks++; if (es_forward[0] !== 1'b0) begin failures++; $display("FAIL reset_fwd_valid: got %b expected 0", es_forward[0]); end
    checks++; if (data_sram_en !== 1'b0) begin failures++; $display("FAIL reset_sram_en: got %b expected 0", data_sram_en); end
    reset = 1'b0;
    step();
    checks++; if (es_allowin !== 1'b1) begin failures++; $display("FAIL reset_allowin: got %b expected 1", es_allowin); end
    checks++; if (es_to_ms_valid !== 1'b0) begin failures++; $display("FAIL post_reset_valid: got %b expected 0", es_to_ms_valid); end
  endtask

  task automatic test_add();
    ms_allowin = 1'b1;
    ds_to_es_bus = mk(32'h1C00_0100, LS_NONE, 32'd0, 32'd7, 32'd5, 1'b0, OP_ADD,
                      1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
    ds_to_es_valid = 1'b1;
    step();
    ds_to_es_valid = 1'b0;
    checks++; if (es_to_ms_valid !== 1'b1) begin failures++; $display("FAIL add_valid: got %b expected 1", es_to_ms_valid); end
    checks++; if (es_to_ms_bus[38:7] !== 32'd12) begin failures++; $display("FAIL add_result: got %h expected %h", es_to_ms_bus[38:7], 32'd12); end
    checks++; if (es_allowin !== 1'b1) begin failures++; $display("FAIL add_allowin: got %b expected 1", es_allowin); end
    checks++; if (es_forward !== {1'b0, 32'h1C00_0100, 32'd12, 5'd3, 1'b1, 1'b1}) begin
      failures++; $display("FAIL add_forward: got %h expected %h", es_forward, {1'b0, 32'h1C00_0100, 32'd12, 5'd3, 1'b1, 1'b1}); end
    checks++; if (es_to_ms_bus[70:39] !== 32'h1C00_0100) begin failures++; $display("FAIL add_pc: got %h expected 1c000100", es_to_ms_bus[70:39]); end
    step();
    checks++; if (es_to_ms_valid !== 1'b0) begin failures++; $display("FAIL add_drain: got %b expected 0", es_to_ms_valid); end
  endtask

  task automatic test_back_to_back();
    ms_allowin = 1'b1;
    for (int i = 0; i < 15; i++) begin
      ds_to_es_bus = mk(32'h1C00_0000 + 32'(4 * i), LS_NONE, 32'd0, alu_b_t[i], alu_a_t[i],
                        1'b0, alu_op_t[i], 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
      ds_to_es_valid = 1'b1;
      step();
      checks++; if (es_to_ms_valid !== 1'b1 || es_allowin !== 1'b1) begin
        failures++; $display("FAIL b2b_hs op%0d: got valid=%b allowin=%b expected 1/1", alu_op_t[i], es_to_ms_valid, es_allowin); end
      checks++; if (es_to_ms_bus[38:7] !== alu_e_t[i]) begin
        failures++; $display("FAIL b2b_result op%0d: got %h expected %h", alu_op_t[i], es_to_ms_bus[38:7], alu_e_t[i]); end
    end
    ds_to_es_valid = 1'b0;
    step();
  endtask

  task automatic test_store();
    logic [7:0]  ls[3]   = '{LS_STB, LS_STH, LS_STW};
    logic [31:0] imm[3]  = '{32'd3, 32'd2, 32'd0};
    logic [3:0]  we[3]   = '{4'b1000, 4'b1100, 4'b1111};
    logic [31:0] wd[3]   = '{32'h7878_7878, 32'h5678_5678, 32'h1234_5678};
    ms_allowin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ds_to_es_bus = mk(32'h1C00_0200, ls[i], imm[i], 32'h1234_5678, 32'h0000_1000, 1'b1,
                        OP_ADD, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
      ds_to_es_valid = 1'b1;
      step();
      checks++; if (data_sram_en !== 1'b1) begin failures++; $display("FAIL store%0d_en: got %b expected 1", i, data_sram_en); end
      checks++; if (data_sram_we !== we[i]) begin failures++; $display("FAIL store%0d_we: got %b expected %b", i, data_sram_we, we[i]); end
      checks++; if (data_sram_addr !== 32'h1000 + imm[i]) begin failures++; $display("FAIL store%0d_addr: got %h expected %h", i, data_sram_addr, 32'h1000 + imm[i]); end
      checks++; if (data_sram_wdata !== wd[i]) begin failures++; $display("FAIL store%0d_wdata: got %h expected %h", i, data_sram_wdata, wd[i]); end
      checks++; if (es_forward[1] !== 1'b0 || es_forward[71] !== 1'b0) begin
        failures++; $display("FAIL store%0d_fwd: got gr_we=%b is_load=%b expected 0/0", i, es_forward[1], es_forward[71]); end
    end
    ds_to_es_valid = 1'b0;
    step();
  endtask

  task automatic test_load_stall();
    ms_allowin = 1'b0;
    ds_to_es_bus = mk(32'h1C00_0300, LS_LDW, 32'd8, 32'd0, 32'h0000_2000, 1'b1, OP_ADD,
                      1'b1, 1'b0, 5'd4, 1'b1, 1'b1);
    ds_to_es_valid = 1'b1;
    step();
    ds_to_es_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (data_sram_en !== 1'b0) begin failures++; $display("FAIL load_stall_en c%0d: got %b expected 0", c, data_sram_en); end
      checks++; if (es_forward[71] !== 1'b1 || es_allowin !== 1'b0) begin
        failures++; $display("FAIL load_stall_fwd c%0d: got is_load=%b allowin=%b expected 1/0", c, es_forward[71], es_allowin); end
      step();
    end
    ms_allowin = 1'b1;
    #1;
    checks++; if (data_sram_en !== 1'b1) begin failures++; $display("FAIL load_go_en: got %b expected 1", data_sram_en); end
    checks++; if (data_sram_addr !== 32'h2008 || data_sram_we !== 4'b0000) begin
      failures++; $display("FAIL load_go_addr: got %h/%b expected 00002008/0000", data_sram_addr, data_sram_we); end
    checks++; if (es_forward[71] !== 1'b1 || es_to_ms_bus[75:71] !== 5'b00100 || es_to_ms_bus[38:7] !== 32'h2008) begin
      failures++; $display("FAIL load_go_bus: got is_load=%b ld=%b res=%h expected 1/00100/00002008", es_forward[71], es_to_ms_bus[75:71], es_to_ms_bus[38:7]); end
    step();
    checks++; if (data_sram_en !== 1'b0) begin failures++; $display("FAIL load_after_en: got %b expected 0", data_sram_en); end
  endtask

  task automatic run_div(input int op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat, input string name);
    int   lat;
    int   stall;
    logic done;
    ms_allowin = 1'b1;
    ds_to_es_bus = mk(32'h1C00_0400, LS_NONE, 32'd0, b, a, 1'b0, op, 1'b0, 1'b0,
                      5'd9, 1'b1, 1'b0);
    ds_to_es_valid = 1'b1;
    step();
    ds_to_es_valid = 1'b0;
    lat = 0;
    stall = 0;
    done = 1'b0;
    for (int k = 1; k <= 100 && !done; k++) begin
      if (es_to_ms_valid) begin
        lat = k;
        done = 1'b1;
        checks++; if (es_to_ms_bus[38:7] !== exp) begin
          failures++; $display("FAIL %s_result: got %h expected %h", name, es_to_ms_bus[38:7], exp); end
      end else begin
        if (!es_allowin) stall++;
        step();
      end
    end
    checks++; if (lat !== exp_lat) begin failures++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat); end
    checks++; if (stall !== exp_lat - 1) begin failures++; $display("FAIL %s_stall: got %0d expected %0d", name, stall, exp_lat - 1); end
    step();
    checks++; if (es_to_ms_valid !== 1'b0) begin failures++; $display("FAIL %s_leave: got %b expected 0", name, es_to_ms_valid); end
  endtask

  task automatic test_divide();
    int zlat;
`ifdef ES_DIV_ZERO_FAST_EN
    zlat = 2;
`else
    zlat = 34;
`endif
    run_div(OP_DIVW,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 34,   "divw_neg7_2");
    run_div(OP_MODW,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 34,   "modw_neg7_2");
    run_div(OP_DIVW,  32'd7,         32'hFFFF_FFFE,  32'hFFFF_FFFD, 34,   "divw_7_neg2");
    run_div(OP_MODW,  32'd7,         32'hFFFF_FFFE,  32'd1,         34,   "modw_7_neg2");
    run_div(OP_DIVW,  32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 34,   "divw_ovf");
    run_div(OP_MODW,  32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         34,   "modw_ovf");
    run_div(OP_DIVWU, 32'd10,        32'd0,          32'hFFFF_FFFF, zlat, "divwu_zero");
    run_div(OP_MODWU, 32'd10,        32'd0,          32'd10,        zlat, "modwu_zero");
    run_div(OP_DIVW,  32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFFF, zlat, "divw_zero");
    run_div(OP_MODW,  32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, zlat, "modw_zero");
  endtask

  task automatic test_div_hold();
    logic done;
    ms_allowin = 1'b0;
    ds_to_es_bus = mk(32'h1C00_0500, LS_NONE, 32'd0, 32'd7, 32'd100, 1'b0, OP_DIVWU,
                      1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
    ds_to_es_valid = 1'b1;
    step();
    ds_to_es_valid = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      if (es_to_ms_valid) done = 1'b1;
      else step();
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL hold_timeout: got no valid expected valid"); end
    for (int c = 0; c < 3; c++) begin
      checks++; if (es_to_ms_valid !== 1'b1 || es_allowin !== 1'b0 || es_to_ms_bus[38:7] !== 32'd14) begin
        failures++; $display("FAIL hold_c%0d: got valid=%b allowin=%b res=%h expected 1/0/0000000e", c, es_to_ms_valid, es_allowin, es_to_ms_bus[38:7]); end
      step();
    end
    ms_allowin = 1'b1;
    #1;
    checks++; if (es_allowin !== 1'b1) begin failures++; $display("FAIL hold_release: got %b expected 1", es_allowin); end
    step();
    checks++; if (es_to_ms_valid !== 1'b0) begin failures++; $display("FAIL hold_leave: got %b expected 0", es_to_ms_valid); end
  endtask

  task automatic test_reset_mid_div();
    ms_allowin = 1'b1;
    ds_to_es_bus = mk(32'h1C00_0600, LS_NONE, 32'd0, 32'd3, 32'd100, 1'b0, OP_DIVW,
                      1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
    ds_to_es_valid = 1'b1;
    step();
    ds_to_es_valid = 1'b0;
    for (int c = 1; c < 10; c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (es_to_ms_valid !== 1'b0 || es_forward[0] !== 1'b0 || es_allowin !== 1'b1) begin
      failures++; $display("FAIL midreset_state: got valid=%b fwd=%b allowin=%b expected 0/0/1", es_to_ms_valid, es_forward[0], es_allowin); end
    ds_to_es_bus = mk(32'h1C00_0700, LS_NONE, 32'd0, 32'd7, 32'd5, 1'b0, OP_ADD,
                      1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
    ds_to_es_valid = 1'b1;
    step();
    ds_to_es_valid = 1'b0;
    checks++; if (es_to_ms_valid !== 1'b1 || es_to_ms_bus[38:7] !== 32'd12) begin
      failures++; $display("FAIL midreset_add: got valid=%b res=%h expected 1/0000000c", es_to_ms_valid, es_to_ms_bus[38:7]); end
    step();
    run_div(OP_DIVWU, 32'd100, 32'd7, 32'd14, 34, "midreset_div");
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_store();
    test_load_stall();
    test_divide();
    test_div_hold();
    test_reset_mid_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
